// File: rtl/hamming_pkg.sv
// Shared constants and types for the Hamming(21,16) transmit path.
// Used by hamming21_encode and hamming_tx_serializer.
package hamming_pkg;

    localparam int CW_W   = 21;
    localparam int DATA_W = 16;
    localparam int PAR_W  = 5;

    // Codeword position (1-based) of each data bit; powers of two hold parity.
    localparam int DATA_POS [DATA_W] = '{
        3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15, 17, 18, 19, 20, 21
    };

    localparam logic [4:0] CNT_FIRST = 5'd1;
    localparam logic [4:0] CNT_LAST  = 5'd21;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

endpackage

// File: rtl/hamming21_encode.sv
// Combinational Hamming(21,16) encoder, even parity at positions 1,2,4,8,16.
// Output bit p-1 carries codeword position p.
module hamming21_encode
    import hamming_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    output logic [CW_W-1:0]   code
);

    logic [CW_W-1:0] dmap;
    logic            par;

    // Scatter the data bits onto their non-power-of-two positions.
    always_comb begin
        dmap = '0;
        for (int i = 0; i < DATA_W; i++) begin
            dmap[DATA_POS[i]-1] = data[i];
        end
    end

    // Each parity bit covers every position whose index has bit k set.
    always_comb begin
        code = dmap;
        par  = 1'b0;
        for (int k = 0; k < PAR_W; k++) begin
            par = 1'b0;
            for (int p = 1; p <= CW_W; p++) begin
                if (((p >> k) & 1) == 1) begin
                    par = par ^ dmap[p-1];
                end
            end
            code[(1 << k)-1] = par;
        end
    end

endmodule

// File: rtl/hamming_tx_serializer.sv
// Hamming(21,16) transmit serializer: encode, then shift out position 1 first.
// Optional error injection on the loaded codeword: HAMMING_TX_ERRINJ_EN.
module hamming_tx_serializer
    import hamming_pkg::*;
#(
    parameter int GAP_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              ser_ready,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              sof,
    output logic              eof,
    output logic              busy
`ifdef HAMMING_TX_ERRINJ_EN
    ,
    input  logic              err_inj,
    input  logic [4:0]        err_pos
`endif
);

    localparam int GAP_W = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LAST =
        GAP_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    state_t           state_q;
    state_t           state_d;
    logic [CW_W-1:0]  sreg_q;
    logic [4:0]       cnt_q;
    logic [GAP_W-1:0] gap_q;

    logic [CW_W-1:0]  code;
    logic [CW_W-1:0]  flip;
    logic [CW_W-1:0]  load_word;
    logic             load;
    logic             adv;
    logic             gap_clr;
    logic             gap_inc;

    hamming21_encode u_enc (
        .data (data_in),
        .code (code)
    );

`ifdef HAMMING_TX_ERRINJ_EN
    // Select the single codeword position to invert; out-of-range flips nothing.
    always_comb begin
        flip = '0;
        for (int p = 1; p <= CW_W; p++) begin
            if (err_inj && (err_pos == 5'(p))) begin
                flip[p-1] = 1'b1;
            end
        end
    end
`else
    assign flip = '0;
`endif

    assign load_word = code ^ flip;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        adv      = 1'b0;
        gap_clr  = 1'b0;
        gap_inc  = 1'b0;
        in_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (ser_ready) begin
                    if (cnt_q == CNT_LAST) begin
                        if (GAP_CYCLES == 0) begin
                            in_ready = 1'b1;
                            if (in_valid) begin
                                load = 1'b1;
                            end else begin
                                state_d = IDLE;
                            end
                        end else begin
                            gap_clr = 1'b1;
                            state_d = GAP;
                        end
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_inc = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Shift register, bit counter and gap counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q <= '0;
            cnt_q  <= '0;
            gap_q  <= '0;
        end else begin
            if (load) begin
                sreg_q <= load_word;
                cnt_q  <= CNT_FIRST;
            end else if (adv) begin
                sreg_q <= sreg_q >> 1;
                cnt_q  <= cnt_q + 5'd1;
            end
            if (gap_clr) begin
                gap_q <= '0;
            end else if (gap_inc) begin
                gap_q <= gap_q + 1'b1;
            end
        end
    end

    assign ser_valid = (state_q == SHIFT);
    assign ser_out   = ser_valid & sreg_q[0];
    assign sof       = ser_valid && (cnt_q == CNT_FIRST);
    assign eof       = ser_valid && (cnt_q == CNT_LAST);
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_hamming_tx_serializer.sv
// Self-checking bench for hamming_tx_serializer (GAP_CYCLES 0 and 3).
// Define HAMMING_TX_ERRINJ_EN to also exercise error injection.
module tb_hamming_tx_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] data_in;
    logic        in_valid;
    logic        in_ready;
    logic        ser_ready;
    logic        ser_out;
    logic        ser_valid;
    logic        sof;
    logic        eof;
    logic        busy;

    logic [15:0] d3_data;
    logic        d3_in_valid;
    logic        d3_in_ready;
    logic        d3_ser_ready;
    logic        d3_ser_out;
    logic        d3_ser_valid;
    logic        d3_sof;
    logic        d3_eof;
    logic        d3_busy;

    logic        err_inj;
    logic [4:0]  err_pos;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] data;
        logic [20:0] cw;
    } vec_t;

    typedef struct {
        bit b;
        int pos;
    } sbit_t;

    vec_t  vecs [5];
    sbit_t q [$];

    hamming_tx_serializer #(.GAP_CYCLES(0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ser_ready (ser_ready),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .sof       (sof),
        .eof       (eof),
        .busy      (busy)
`ifdef HAMMING_TX_ERRINJ_EN
        ,
        .err_inj   (err_inj),
        .err_pos   (err_pos)
`endif
    );

    hamming_tx_serializer #(.GAP_CYCLES(3)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (d3_data),
        .in_valid  (d3_in_valid),
        .in_ready  (d3_in_ready),
        .ser_ready (d3_ser_ready),
        .ser_out   (d3_ser_out),
        .ser_valid (d3_ser_valid),
        .sof       (d3_sof),
        .eof       (d3_eof),
        .busy      (d3_busy)
`ifdef HAMMING_TX_ERRINJ_EN
        ,
        .err_inj   (err_inj),
        .err_pos   (err_pos)
`endif
    );

    initial forever #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string nm, input logic [63:0] act,
                                input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Reference codeword from the Hamming rules; bit p-1 = position p.
    function automatic logic [20:0] model_cw(input logic [15:0] d);
        bit          c [22];
        int          j;
        bit          x;
        logic [20:0] r;
        j = 0;
        for (int p = 0; p <= 21; p++) c[p] = 1'b0;
        for (int p = 1; p <= 21; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[p] = d[j];
                j++;
            end
        end
        for (int pp = 1; pp <= 16; pp = pp * 2) begin
            x = 1'b0;
            for (int p = 1; p <= 21; p++) begin
                if (((p & pp) != 0) && (p != pp)) x = x ^ c[p];
            end
            c[pp] = x;
        end
        for (int p = 1; p <= 21; p++) r[p-1] = c[p];
        return r;
    endfunction

    // Send one word to the GAP_CYCLES=0 instance and collect its 21 bits.
    task automatic run_frame(input logic [15:0] d, input bit stall,
                             input string nm, output logic [20:0] got);
        int   k;
        int   guard;
        bit   held;
        logic prev_out;
        got      = '0;
        k        = 1;
        guard    = 0;
        held     = 1'b0;
        prev_out = 1'b0;
        data_in   = d;
        in_valid  = 1'b1;
        ser_ready = 1'b1;
        #1;
        chk({nm, " ready before accept"}, in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        while (k <= 21 && guard < 100) begin
            ser_ready = stall ? ((guard % 2) == 1) : 1'b1;
            #1;
            chk({nm, " valid"}, ser_valid, 1'b1);
            chk({nm, " sof"}, sof, (k == 1));
            chk({nm, " eof"}, eof, (k == 21));
            if (held) chk({nm, " hold"}, ser_out, prev_out);
            held     = !ser_ready;
            prev_out = ser_out;
            if (ser_ready) begin
                got[k-1] = ser_out;
                k++;
            end
            @(negedge clk);
            guard++;
        end
        ser_ready = 1'b1;
        chk({nm, " frame complete"}, (k > 21), 1'b1);
    endtask

    initial begin
        logic [20:0] got;
        logic [41:0] bits;
        int          n;
        int          cyc;
        int          acc;
        int          first_eof;
        int          second_sof;
        bit          gapseen;
        bit          seen;
        bit          rdy;
        bit          exp_ir;
        logic [20:0] mcw;

        vecs[0] = '{16'h0000, 21'h000000};
        vecs[1] = '{16'hFFFF, 21'h1FFFFE};
        vecs[2] = '{16'h0001, 21'h000007};
        vecs[3] = '{16'hA5C3, 21'h145C1D};
        vecs[4] = '{16'h8000, 21'h108009};

        rst_n        = 1'b0;
        data_in      = '0;
        in_valid     = 1'b0;
        ser_ready    = 1'b1;
        d3_data      = '0;
        d3_in_valid  = 1'b0;
        d3_ser_ready = 1'b1;
        err_inj      = 1'b0;
        err_pos      = '0;

        repeat (3) @(negedge clk);
        #1;
        chk("reset in_ready", in_ready, 1'b1);
        chk("reset ser_valid", ser_valid, 1'b0);
        chk("reset ser_out", ser_out, 1'b0);
        chk("reset sof", sof, 1'b0);
        chk("reset eof", eof, 1'b0);
        chk("reset busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i].data, 1'b0, "vec", got);
            chk($sformatf("vec %0h codeword", vecs[i].data), got, vecs[i].cw);
        end

        run_frame(16'hA5C3, 1'b1, "stall", got);
        chk("stall codeword", got, 21'h145C1D);

        // Back-to-back: 0xFFFF then 0x0001 with no dead cycle.
        data_in   = 16'hFFFF;
        in_valid  = 1'b1;
        ser_ready = 1'b1;
        @(negedge clk);
        acc        = 1;
        n          = 0;
        cyc        = 0;
        first_eof  = -1;
        second_sof = -1;
        gapseen    = 1'b0;
        bits       = '0;
        data_in    = 16'h0001;
        while (n < 42 && cyc < 80) begin
            in_valid = (acc < 2);
            #1;
            if (in_valid && in_ready) acc++;
            if (ser_valid) begin
                bits[n] = ser_out;
                if (eof && first_eof < 0) first_eof = cyc;
                if (sof && cyc > 0) second_sof = cyc;
                n++;
            end else begin
                gapseen = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        chk("b2b bit count", n, 42);
        chk("b2b contiguous", gapseen, 1'b0);
        chk("b2b first eof cycle", first_eof, 20);
        chk("b2b sof after eof", second_sof, first_eof + 1);
        chk("b2b stream", bits, {21'h000007, 21'h1FFFFE});

        // GAP_CYCLES=3: in_ready returns 4 cycles after eof.
        d3_data      = 16'h1234;
        d3_in_valid  = 1'b1;
        d3_ser_ready = 1'b1;
        @(negedge clk);
        d3_in_valid = 1'b0;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 50) begin
            #1;
            if (d3_eof) seen = 1'b1;
            @(negedge clk);
            cyc++;
        end
        chk("gap eof reached", seen, 1'b1);
        chk("gap eof cycle", cyc, 21);
        d3_ser_ready = 1'b0;
        n   = 1;
        rdy = 1'b0;
        while (!rdy && n < 20) begin
            #1;
            if (d3_in_ready) begin
                rdy = 1'b1;
            end else begin
                chk("gap busy", d3_busy, 1'b1);
                chk("gap ser_valid", d3_ser_valid, 1'b0);
                @(negedge clk);
                n++;
            end
        end
        chk("gap in_ready delay", n, 4);
        chk("gap idle busy", d3_busy, 1'b0);
        d3_ser_ready = 1'b1;

        // Reset mid-frame abandons the frame at once.
        data_in   = 16'hFFFF;
        in_valid  = 1'b1;
        ser_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("pre-reset mid-frame bit", ser_out, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midreset in_ready", in_ready, 1'b1);
        chk("midreset ser_valid", ser_valid, 1'b0);
        chk("midreset ser_out", ser_out, 1'b0);
        chk("midreset sof", sof, 1'b0);
        chk("midreset eof", eof, 1'b0);
        chk("midreset busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("postreset in_ready", in_ready, 1'b1);
        chk("postreset busy", busy, 1'b0);
        @(negedge clk);
        run_frame(16'h8000, 1'b0, "postreset", got);
        chk("postreset codeword", got, 21'h108009);

`ifdef HAMMING_TX_ERRINJ_EN
        err_inj = 1'b1;
        err_pos = 5'd5;
        run_frame(16'h0000, 1'b0, "inj5", got);
        chk("inj pos5 codeword", got, 21'h000010);
        err_pos = 5'd22;
        run_frame(16'h0000, 1'b0, "inj22", got);
        chk("inj pos22 codeword", got, 21'h000000);
        err_pos = 5'd0;
        run_frame(16'h0000, 1'b0, "inj0", got);
        chk("inj pos0 codeword", got, 21'h000000);
        err_pos = 5'd21;
        run_frame(16'h0000, 1'b0, "inj21", got);
        chk("inj pos21 codeword", got, 21'h100000);
        err_inj = 1'b0;
        err_pos = '0;
`endif

        // Randomized traffic against a bit-queue model of the channel.
        q.delete();
        for (int c = 0; c < 800; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            data_in   = 16'($urandom);
            ser_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_ir = (q.size() == 0) || (q.size() == 1 && ser_ready);
            chk("rnd in_ready", in_ready, exp_ir);
            chk("rnd ser_valid", ser_valid, (q.size() != 0));
            chk("rnd busy", busy, (q.size() != 0));
            if (q.size() != 0) begin
                chk("rnd ser_out", ser_out, q[0].b);
                chk("rnd sof", sof, (q[0].pos == 1));
                chk("rnd eof", eof, (q[0].pos == 21));
            end else begin
                chk("rnd idle ser_out", ser_out, 1'b0);
            end
            if (q.size() != 0 && ser_ready) void'(q.pop_front());
            if (in_valid && exp_ir) begin
                mcw = model_cw(data_in);
                for (int p = 1; p <= 21; p++) q.push_back('{mcw[p-1], p});
            end
            @(negedge clk);
        end
        in_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
